// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator: state encoding, default bus
// widths, response codes and the wait-timer width helper.
package apb_pkg;

  // FSM state encoding, kept as plain constants for legacy tool flows
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SETUP  = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;

  // Default bus geometry matching the 4-register UART control slave
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 8;

  // rsp_err values reported alongside rsp_valid
  localparam logic RSP_OK          = 1'b0;
  localparam logic RSP_ERR_TIMEOUT = 1'b1;

  // Width needed to count 0..timeout; never narrower than one bit
  function automatic int timer_width(input int timeout);
    if (timeout <= 0) return 1;
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase. Counts cycles while enabled and
// flags when the count sits on the last permitted wait cycle. A TIMEOUT of
// zero disables the expiry flag entirely.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W  = timer_width(TIMEOUT);
  localparam int LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] LAST = LAST_I[CNT_W-1:0];

  logic [CNT_W-1:0] count;

  // Count stalled ACCESS cycles; clear takes priority when a new transfer starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB initiator for the UART register slave. Accepts single read/write
// commands on a valid/ready interface, runs the SETUP/ACCESS sequence,
// honours pready wait states and aborts with an error response when the
// slave stalls for too long.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  logic [1:0] state;
  logic       timer_clr;
  logic       timer_en;
  logic       timer_expired;

  // Ready depends on state alone so the command source sees no loop through cmd_valid
  assign cmd_ready = (state == IDLE);

  // Counter restarts on every accepted command and runs only on stalled ACCESS cycles
  assign timer_clr = (state == IDLE) && cmd_valid;
  assign timer_en  = (state == ACCESS) && !pready;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (pclk),
    .rst_n   (presetn),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Transfer sequencer: owns the bus drive registers and the response pulse
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= RSP_OK;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= RSP_OK;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_wdata;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // A ready slave beats an expiring timer on the same edge
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= RSP_OK;
            if (!pwrite) rsp_rdata <= prdata;
            state     <= IDLE;
          end else if (timer_expired) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= RSP_ERR_TIMEOUT;
            rsp_rdata <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
